median_search_ctrl: RTL and testbench
=====================================

Name: median_search_ctrl

Overview:
- Sequencer that finds the median of a stored sample window by bitwise binary search over ADC codes.
- Drives one external median-searcher instance: candidate value, streamed samples, and searcher reset.
- Reads the searcher's a_or_b verdict once per bit.
- Sits between the window sample buffer (1-cycle read latency) and the wavelet threshold logic that consumes the median.

Parameters:
ADC_WIDTH, 14, sample/candidate width; codes are unsigned.
MAX_WINDOW_SIZE, 1024, maximum window length in samples.
MAX_WINDOW_LOG, $clog2(MAX_WINDOW_SIZE), localparam; address and config width.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  request a search; sampled only in IDLE.
window_size_cfg  in  MAX_WINDOW_LOG  window length N; 0 means MAX_WINDOW_SIZE; captured on start acceptance.
busy  out  1  high from start acceptance through DONE.
done  out  1  single-cycle pulse; median_o valid that cycle and held until next start.
median_o  out  ADC_WIDTH  search result.
rd_en  out  1  buffer read strobe.
rd_addr  out  MAX_WINDOW_LOG  buffer address.
rd_data  in  ADC_WIDTH  buffer data, valid 1 cycle after rd_en.
srch_median_o  out  ADC_WIDTH  candidate to searcher median_i.
srch_detail_o  out  ADC_WIDTH  sample to searcher detail_level.
srch_reset_o  out  1  searcher reset; the searcher counts on every cycle this is low, and latches a_or_b on the cycle it is high.
srch_a_or_b_i  in  1  searcher verdict: count(sample>=candidate) >= count(sample<candidate).

Behaviour:
- Reset values: busy=0, done=0, median_o=0, rd_en=0, rd_addr=0, srch_median_o=0, srch_detail_o=0, srch_reset_o=1. State returns to IDLE.
- Reset mid-search aborts immediately. No done pulse is issued. srch_reset_o stays high.
- Median definition: the largest v where the searcher verdict is true (upper median for even N).
- States: IDLE, SETUP, STREAM, LATCH, DECIDE, DONE.
- IDLE:
  - srch_reset_o=1.
  - On start=1: capture N, set bit_idx=ADC_WIDTH-1, result=0, busy=1, go to SETUP.
- SETUP (1 cycle):
  - srch_median_o = result | (1<<bit_idx).
  - srch_reset_o=1, which clears the searcher counters.
  - rd_en=1, rd_addr=0, smp_cnt=0.
  - Go to STREAM.
- STREAM (exactly N cycles):
  - srch_reset_o=0.
  - srch_detail_o = rd_data, combinational pass-through.
  - rd_en=1 and rd_addr increments while issued addresses < N. No read is issued in the last STREAM cycle.
  - After the N-th cycle, go to LATCH.
- LATCH (1 cycle):
  - srch_reset_o=1. The searcher latches a_or_b from N counted samples and clears.
  - rd_en=0.
- DECIDE (1 cycle):
  - If srch_a_or_b_i=1, set result bit bit_idx to 1; otherwise leave it 0.
  - If bit_idx==0, go to DONE. Else decrement bit_idx and go to SETUP.
- DONE (1 cycle):
  - median_o=result, done=1, busy stays 1.
  - Next state IDLE, with busy=0 in IDLE.
- Timing:
  - Per-bit cost is N+3 cycles.
  - done is high on cycle ADC_WIDTH*(N+3)+1 after the start-accepting edge.
- start while busy is ignored, not queued. start held high in DONE is not seen until IDLE, so the earliest restart is the cycle after DONE.
- srch_reset_o is low only during STREAM, so no spurious counts occur.
- Candidate arithmetic is an unsigned bit-set with no overflow.
- Address count uses MAX_WINDOW_LOG+1 internal bits so N=MAX_WINDOW_SIZE terminates correctly. rd_addr never exceeds N-1.
- window_size_cfg changes during a search have no effect.

Test Plan:
- Buffer {10,20,30,40}, cfg=4, start pulse, real searcher instance -> median_o=30; done exactly 14*7+1=99 cycles after start edge; busy high 99 cycles.
- Buffer {5,100,7}, cfg=3 -> median_o=7; rd_addr sequence per pass 0,1,2; exactly 3 srch_reset_o-low cycles per pass, 14 passes.
- All-equal window of 0x1FFF, cfg=8 -> median_o=0x1FFF. All zeros -> median_o=0.
- cfg=0 with 1024 samples 0..1023 -> median_o=512; rd_addr max 1023; done at 14*1027+1 cycles.
- Assert reset during STREAM of bit 9 -> next cycle busy=0, srch_reset_o=1, no done. A new start then yields the correct median.
- start re-pulsed while busy and window_size_cfg changed mid-search -> ignored; single done; result matches the captured N.

Source files
------------

// File: rtl/median_search_ctrl.sv
// Median sequencer: binary search over ADC codes, one bit per pass over the window.
// Each pass streams the window into an external searcher and keeps the bit if its verdict is true.
module median_search_ctrl #(
    parameter int ADC_WIDTH       = 14,
    parameter int MAX_WINDOW_SIZE = 1024,
    localparam int MAX_WINDOW_LOG = $clog2(MAX_WINDOW_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MAX_WINDOW_LOG-1:0] window_size_cfg,
    output logic                      busy,
    output logic                      done,
    output logic [ADC_WIDTH-1:0]      median_o,
    output logic                      rd_en,
    output logic [MAX_WINDOW_LOG-1:0] rd_addr,
    input  logic [ADC_WIDTH-1:0]      rd_data,
    output logic [ADC_WIDTH-1:0]      srch_median_o,
    output logic [ADC_WIDTH-1:0]      srch_detail_o,
    output logic                      srch_reset_o,
    input  logic                      srch_a_or_b_i
);

    localparam int BIT_W = $clog2(ADC_WIDTH);
    localparam logic [MAX_WINDOW_LOG:0] CNT_ONE  = (MAX_WINDOW_LOG+1)'(1);
    localparam logic [MAX_WINDOW_LOG:0] CNT_FULL = (MAX_WINDOW_LOG+1)'(MAX_WINDOW_SIZE);
    localparam logic [ADC_WIDTH-1:0]    MASK_ONE = ADC_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STREAM,
        LATCH,
        DECIDE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [MAX_WINDOW_LOG:0] n_q, n_d;
    logic [MAX_WINDOW_LOG:0] cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
    logic [ADC_WIDTH-1:0]    result_q, result_d;
    logic [ADC_WIDTH-1:0]    median_q, median_d;
    logic [ADC_WIDTH-1:0]    cand_q, cand_d;
    logic [ADC_WIDTH-1:0]    bit_mask;
    logic [MAX_WINDOW_LOG:0] nxt_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            result_q  <= '0;
            median_q  <= '0;
            cand_q    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            result_q  <= result_d;
            median_q  <= median_d;
            cand_q    <= cand_d;
        end
    end

    assign bit_mask      = MASK_ONE << bit_idx_q;
    assign nxt_addr      = cnt_q + CNT_ONE;
    assign median_o      = median_q;
    assign srch_median_o = cand_q;

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        result_d      = result_q;
        median_d      = median_q;
        cand_d        = cand_q;
        busy          = 1'b1;
        done          = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        srch_detail_o = '0;
        srch_reset_o  = 1'b1;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    n_d       = (window_size_cfg == '0) ? CNT_FULL : {1'b0, window_size_cfg};
                    bit_idx_d = BIT_W'(ADC_WIDTH - 1);
                    result_d  = '0;
                    cand_d    = MASK_ONE << (ADC_WIDTH - 1);
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                rd_en   = 1'b1;
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                // cnt_q is the sample currently on rd_data; prefetch the next one if it exists
                srch_reset_o  = 1'b0;
                srch_detail_o = rd_data;
                cnt_d         = nxt_addr;
                if (nxt_addr < n_q) begin
                    rd_en   = 1'b1;
                    rd_addr = nxt_addr[MAX_WINDOW_LOG-1:0];
                end
                if (cnt_q == n_q - CNT_ONE) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                if (srch_a_or_b_i) begin
                    result_d = result_q | bit_mask;
                end
                if (bit_idx_q == '0) begin
                    median_d = result_d;
                    state_d  = DONE;
                end else begin
                    bit_idx_d = bit_idx_q - BIT_W'(1);
                    cand_d    = result_d | (bit_mask >> 1);
                    state_d   = SETUP;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_median_search_ctrl.sv
// Bench for median_search_ctrl with a behavioural sample buffer and median searcher.
// Expected medians are queued at start; a monitor pops and compares on each done pulse.
module tb_median_search_ctrl;

    localparam int AW  = 14;
    localparam int MWS = 1024;
    localparam int LOG = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [LOG-1:0] cfg;
    logic           busy, done, rd_en, srch_reset_o;
    logic [AW-1:0]  median_o, srch_median_o, srch_detail_o;
    logic [LOG-1:0] rd_addr;
    logic [AW-1:0]  rd_data = '0;
    logic           a_or_b = 1'b0;

    logic [AW-1:0]  mem [MWS];
    int             ge_cnt = 0, lt_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    median_search_ctrl #(.ADC_WIDTH(AW), .MAX_WINDOW_SIZE(MWS)) dut (
        .clk(clk), .reset(reset), .start(start), .window_size_cfg(cfg),
        .busy(busy), .done(done), .median_o(median_o),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .srch_median_o(srch_median_o), .srch_detail_o(srch_detail_o),
        .srch_reset_o(srch_reset_o), .srch_a_or_b_i(a_or_b)
    );

    // Buffer with one cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Searcher: counts while its reset is low, latches the verdict while it is high
    always @(posedge clk) begin
        if (srch_reset_o) begin
            a_or_b <= (ge_cnt >= lt_cnt);
            ge_cnt <= 0;
            lt_cnt <= 0;
        end else if (srch_detail_o >= srch_median_o) begin
            ge_cnt <= ge_cnt + 1;
        end else begin
            lt_cnt <= lt_cnt + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with median %0d, expected none", median_o);
                end else begin
                    e = exp_q.pop_front();
                    check("median", median_o, e);
                end
            end
        end
    end

    task automatic run(input int cfg_v, input int n, input int exp_med, input bit disturb);
        int  done_cyc, busy_cyc, addr_err, max_a, exp_a, passes, seg_len, seg_err, rd_cnt, d0, limit;
        bit  prev_en, seen;
        done_cyc = -1; busy_cyc = 0; addr_err = 0; max_a = 0; exp_a = 0;
        passes = 0; seg_len = 0; seg_err = 0; rd_cnt = 0; prev_en = 0; seen = 0;
        limit = 14 * (n + 3) + 20;
        @(negedge clk);
        cfg   = LOG'(cfg_v);
        start = 1'b1;
        exp_q.push_back(exp_med);
        d0 = done_cnt;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= limit && !seen; c++) begin
            @(negedge clk);
            if (disturb && c >= 20 && c < 25) begin
                start = 1'b1;
                cfg   = LOG'(1);
            end else if (disturb && c == 25) begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (rd_en) begin
                if (!prev_en) exp_a = 0;
                if (int'(rd_addr) != exp_a) addr_err++;
                if (int'(rd_addr) > max_a) max_a = int'(rd_addr);
                exp_a++;
                rd_cnt++;
            end
            prev_en = rd_en;
            if (!srch_reset_o) begin
                seg_len++;
            end else if (seg_len > 0) begin
                passes++;
                if (seg_len != n) seg_err++;
                seg_len = 0;
            end
            if (done) begin
                done_cyc = c;
                seen     = 1'b1;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_cycle", done_cyc, 14 * (n + 3) + 1);
        check("busy_cycles", busy_cyc, 14 * (n + 3) + 1);
        check("busy_after_done", busy, 0);
        check("done_count", done_cnt - d0, 1);
        check("addr_seq_errors", addr_err, 0);
        check("max_rd_addr", max_a, n - 1);
        check("rd_strobes", rd_cnt, 14 * n);
        check("stream_passes", passes, 14);
        check("stream_len_errors", seg_err, 0);
    endtask

    task automatic abort_in_bit9();
        int  entries;
        bit  prev_sr;
        entries = 0;
        prev_sr = 1'b1;
        @(negedge clk);
        cfg   = LOG'(4);
        start = 1'b1;
        exp_q.push_back(30);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 400 && entries < 5; c++) begin
            @(negedge clk);
            if (!srch_reset_o && prev_sr) entries++;
            prev_sr = srch_reset_o;
        end
        check("abort_reached_bit9", entries, 5);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_srch_reset", srch_reset_o, 1);
        check("abort_done", done, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_still_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cfg   = '0;
        for (int i = 0; i < MWS; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_median", median_o, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_srch_median", srch_median_o, 0);
        check("rst_srch_detail", srch_detail_o, 0);
        check("rst_srch_reset", srch_reset_o, 1);
        reset = 1'b0;

        mem[0] = 14'd10; mem[1] = 14'd20; mem[2] = 14'd30; mem[3] = 14'd40;
        run(4, 4, 30, 1'b0);

        mem[0] = 14'd5; mem[1] = 14'd100; mem[2] = 14'd7;
        run(3, 3, 7, 1'b0);

        for (int i = 0; i < 8; i++) mem[i] = 14'h1FFF;
        run(8, 8, 8191, 1'b0);

        for (int i = 0; i < 8; i++) mem[i] = '0;
        run(8, 8, 0, 1'b0);

        for (int i = 0; i < MWS; i++) mem[i] = AW'(i);
        run(0, 1024, 512, 1'b0);

        mem[0] = 14'd10; mem[1] = 14'd20; mem[2] = 14'd30; mem[3] = 14'd40;
        abort_in_bit9();
        run(4, 4, 30, 1'b0);

        run(4, 4, 30, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
